// File: rtl/screen_sequencer_pkg.sv
// ============================================================================
// Module  : screen_pkg
// Purpose : Shared types and widths for the screen sequencer slice
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package screen_pkg;

  localparam int SCREEN_W = 5;
  localparam int TCOUNT_W = 8;

  typedef logic [SCREEN_W-1:0] screen_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TITLE   = 3'd1,
    ST_TRACE   = 3'd2,
    ST_MESSAGE = 3'd3,
    ST_SCORE   = 3'd4,
    ST_RESTART = 3'd5
  } state_e;

  // A game needs at least a title screen and a score board.
  function automatic screen_t clamp_total(input screen_t t);
    return (t < screen_t'(2)) ? screen_t'(2) : t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/screen_sequencer_if.sv
// ============================================================================
// Module  : screen_sequencer_if
// Purpose : Game-flow control and status bundle of the screen sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface screen_sequencer_if;
  import screen_pkg::*;

  logic          start;
  logic          pause;
  logic          trace_done;
  screen_t       total_screens;
  screen_t       curr_screen;
  logic          screen_change;
  logic [15:0]   elapsed_sec;
  logic          snitch_powerup;
  logic          end_of_game;
  logic          play_again;

  // Game logic / stimulus side.
  modport master (
    output start, pause, trace_done, total_screens,
    input  curr_screen, screen_change, elapsed_sec,
           snitch_powerup, end_of_game, play_again
  );

  // Sequencer side.
  modport slave (
    input  start, pause, trace_done, total_screens,
    output curr_screen, screen_change, elapsed_sec,
           snitch_powerup, end_of_game, play_again
  );

endinterface

`default_nettype wire

// File: rtl/screen_sequencer_tick_gen.sv
// ============================================================================
// Module  : tick_gen
// Purpose : Tick prescaler with hold-enable and synchronous clear
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = enable && (r_count == C_LAST);

  // Prescaler: clear wins, otherwise count while enabled and wrap on the tick.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/screen_sequencer.sv
// ============================================================================
// Module  : screen_sequencer
// Purpose : Game-flow FSM sequencing title, trace/message, score and replay
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_sequencer
  import screen_pkg::*;
#(
  parameter int TICK_CYCLES   = 12_500_000,
  parameter int TICKS_PER_SEC = 4,
  parameter int TITLE_TICKS   = 1,
  parameter int TRACE_TICKS   = 80,
  parameter int MSG_TICKS     = 20,
  parameter int SCORE_TICKS   = 16,
  parameter int SNITCH_ON     = 32,
  parameter int SNITCH_OFF    = 60
) (
  input  logic              clock,
  input  logic              resetn,
  screen_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_TITLE   = ST_TITLE;
  localparam logic [2:0] S_TRACE   = ST_TRACE;
  localparam logic [2:0] S_MESSAGE = ST_MESSAGE;
  localparam logic [2:0] S_SCORE   = ST_SCORE;
  localparam logic [2:0] S_RESTART = ST_RESTART;

  localparam logic [TCOUNT_W-1:0] C_TITLE_LAST = TCOUNT_W'(TITLE_TICKS - 1);
  localparam logic [TCOUNT_W-1:0] C_TRACE_LAST = TCOUNT_W'(TRACE_TICKS - 1);
  localparam logic [TCOUNT_W-1:0] C_MSG_LAST   = TCOUNT_W'(MSG_TICKS - 1);
  localparam logic [TCOUNT_W-1:0] C_SCORE_LAST = TCOUNT_W'(SCORE_TICKS - 1);
  localparam logic [TCOUNT_W-1:0] C_SNITCH_ON  = TCOUNT_W'(SNITCH_ON);
  localparam logic [TCOUNT_W-1:0] C_SNITCH_OFF = TCOUNT_W'(SNITCH_OFF);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  screen_t             r_screen;
  screen_t             w_next_screen;
  screen_t             r_total;
  screen_t             w_step;
  logic [TCOUNT_W-1:0] r_tcount;
  logic [TCOUNT_W-1:0] w_next_tcount;
  logic [TCOUNT_W-1:0] w_last;
  logic [SUB_W-1:0]    r_sub;
  logic [15:0]         r_elapsed;
  logic                r_change;
  logic                r_snitch;
  logic                r_eog;
  logic                r_again;
  logic                w_tick;
  logic                w_tick_en;
  logic                w_end;
  logic                w_change;
  logic                w_playing;
  logic                w_clear_time;

  // Screens that count towards play time.
  assign w_playing = (r_state == S_TITLE) || (r_state == S_TRACE) || (r_state == S_MESSAGE);

  // Timing only advances on timed screens and never while paused.
  assign w_tick_en = !bus.pause && (w_playing || (r_state == S_SCORE));

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clock  (clock),
    .resetn (resetn),
    .enable (w_tick_en),
    .clear  (w_change),
    .tick   (w_tick)
  );

  assign w_step = r_screen + 1'b1;

  // Last tick index of the current screen; the screen ends on that tick.
  always_comb begin
    w_last = C_SCORE_LAST;
    case (r_state)
      S_TITLE:   w_last = C_TITLE_LAST;
      S_TRACE:   w_last = C_TRACE_LAST;
      S_MESSAGE: w_last = C_MSG_LAST;
      default:   w_last = C_SCORE_LAST;
    endcase
  end

  assign w_end = w_tick && (r_tcount == w_last);

  // Next state, next screen and screen-change detection.
  always_comb begin
    w_next_state  = r_state;
    w_next_screen = r_screen;
    w_change      = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_TITLE;
      S_TITLE:   w_change = w_end;
      S_MESSAGE: w_change = w_end;
      // trace_done during pause is dropped, so it needs pause low here.
      S_TRACE:   w_change = w_end || (bus.trace_done && !bus.pause);
      S_SCORE: begin
        if (w_end) begin
          w_next_state  = S_RESTART;
          w_next_screen = screen_t'(1);
          w_change      = 1'b1;
        end
      end
      S_RESTART: w_next_state = S_TITLE;
      default:   w_next_state = S_IDLE;
    endcase
    if (w_change && w_playing) begin
      w_next_screen = w_step;
      if (w_step == r_total)  w_next_state = S_SCORE;
      else if (w_step[0])     w_next_state = S_MESSAGE;
      else                    w_next_state = S_TRACE;
    end
    if (w_change)     w_next_tcount = '0;
    else if (w_tick)  w_next_tcount = r_tcount + 1'b1;
    else              w_next_tcount = r_tcount;
  end

  // FSM, tick count and registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_screen <= screen_t'(1);
      r_tcount <= '0;
      r_total  <= screen_t'(2);
      r_change <= 1'b0;
      r_snitch <= 1'b0;
      r_eog    <= 1'b0;
      r_again  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_screen <= w_next_screen;
      r_tcount <= w_next_tcount;
      r_change <= w_change;
      r_again  <= (r_state == S_SCORE) && w_end;
      r_eog    <= (w_next_state == S_SCORE);
      r_snitch <= !bus.pause && (w_next_state == S_TRACE) &&
                  (w_next_tcount >= C_SNITCH_ON) && (w_next_tcount < C_SNITCH_OFF);
      if (((r_state == S_IDLE) && bus.start) || (r_state == S_RESTART)) begin
        r_total <= clamp_total(bus.total_screens);
      end
    end
  end

  // Play time restarts on start and on replay.
  assign w_clear_time = ((r_state == S_IDLE) && bus.start) || ((r_state == S_SCORE) && w_end);

  // Elapsed seconds: divide play ticks down and saturate.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sub     <= '0;
      r_elapsed <= '0;
    end else if (w_clear_time) begin
      r_sub     <= '0;
      r_elapsed <= '0;
    end else if (w_tick && w_playing) begin
      if (r_sub == C_SUB_LAST) begin
        r_sub <= '0;
        if (r_elapsed != 16'hFFFF) r_elapsed <= r_elapsed + 1'b1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

  assign bus.curr_screen    = r_screen;
  assign bus.screen_change  = r_change;
  assign bus.elapsed_sec    = r_elapsed;
  assign bus.snitch_powerup = r_snitch;
  assign bus.end_of_game    = r_eog;
  assign bus.play_again     = r_again;

endmodule

`default_nettype wire

// File: tb/tb_screen_sequencer.sv
// ============================================================================
// Module  : tb_screen_sequencer
// Purpose : Self-checking bench for screen_sequencer (table, directed, random)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int TC      = 4;
  localparam int TPS     = 2;
  localparam int T_TITLE = 1;
  localparam int T_TRACE = 6;
  localparam int T_MSG   = 3;
  localparam int T_SCORE = 2;
  localparam int SN_ON   = 2;
  localparam int SN_OFF  = 4;

  localparam int PH_IDLE    = 0;
  localparam int PH_PLAY    = 1;
  localparam int PH_SCORE   = 2;
  localparam int PH_RESTART = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  screen_sequencer_if bus();

  screen_sequencer #(
    .TICK_CYCLES   (TC),
    .TICKS_PER_SEC (TPS),
    .TITLE_TICKS   (T_TITLE),
    .TRACE_TICKS   (T_TRACE),
    .MSG_TICKS     (T_MSG),
    .SCORE_TICKS   (T_SCORE),
    .SNITCH_ON     (SN_ON),
    .SNITCH_OFF    (SN_OFF)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: game phase, screen, cycles spent on this screen, play ticks.
  int m_phase, m_screen, m_total, m_spent, m_ticks;
  bit m_change, m_again, m_snitch;

  function automatic int screen_ticks(input int s);
    if (s == 1) return T_TITLE;
    return (s % 2 == 0) ? T_TRACE : T_MSG;
  endfunction

  function automatic int min_two(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int exp_elapsed();
    return (m_ticks / TPS > 65535) ? 65535 : m_ticks / TPS;
  endfunction

  task automatic model_step();
    m_change = 1'b0;
    m_again  = 1'b0;
    if (!resetn) begin
      m_phase = PH_IDLE; m_screen = 1; m_total = 2; m_spent = 0; m_ticks = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (bus.start) begin
          m_phase = PH_PLAY; m_total = min_two(int'(bus.total_screens));
          m_ticks = 0; m_spent = 0;
        end
        PH_PLAY: if (!bus.pause) begin
          m_spent++;
          if (m_spent % TC == 0) m_ticks++;
          if (m_spent == screen_ticks(m_screen) * TC || (m_screen % 2 == 0 && bus.trace_done)) begin
            m_screen++; m_spent = 0; m_change = 1'b1;
            if (m_screen == m_total) m_phase = PH_SCORE;
          end
        end
        PH_SCORE: if (!bus.pause) begin
          m_spent++;
          if (m_spent == T_SCORE * TC) begin
            m_phase = PH_RESTART; m_screen = 1; m_change = 1'b1; m_again = 1'b1;
            m_ticks = 0; m_spent = 0;
          end
        end
        default: begin
          m_phase = PH_PLAY; m_total = min_two(int'(bus.total_screens));
        end
      endcase
    end
    m_snitch = resetn && !bus.pause && m_phase == PH_PLAY && m_screen % 2 == 0 &&
               (m_spent / TC) >= SN_ON && (m_spent / TC) < SN_OFF;
  endtask

  task automatic check_model(input string tag);
    total++;
    if (bus.curr_screen !== 5'(m_screen) || bus.screen_change !== m_change ||
        bus.elapsed_sec !== 16'(exp_elapsed()) || bus.snitch_powerup !== m_snitch ||
        bus.end_of_game !== (m_phase == PH_SCORE) || bus.play_again !== m_again) begin
      bad++;
      $display("FAIL %s t=%0t: got scr=%0d chg=%0b el=%0d sn=%0b eog=%0b pa=%0b expected scr=%0d chg=%0b el=%0d sn=%0b eog=%0b pa=%0b",
               tag, $time, bus.curr_screen, bus.screen_change, bus.elapsed_sec, bus.snitch_powerup,
               bus.end_of_game, bus.play_again, m_screen, m_change, exp_elapsed(), m_snitch,
               (m_phase == PH_SCORE), m_again);
    end
  endtask

  task automatic expect_val(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", tag, $time, got, want);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    resetn = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.trace_done = 1'b0;
    bus.total_screens = 5'd5;
    repeat (3) cycle("reset");
    expect_val("rst_screen", int'(bus.curr_screen), 1);
    expect_val("rst_elapsed", int'(bus.elapsed_sec), 0);
    expect_val("rst_eog", int'(bus.end_of_game), 0);
    resetn = 1'b1;
  endtask

  task automatic begin_game(input logic [4:0] tot);
    bus.total_screens = tot;
    bus.start = 1'b1;
    cycle("start");
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic [4:0] tot;
    int         cycles;
    int         scr;
    bit         chg;
    bit         eog;
    bit         pa;
    int         el;
  } vec_t;

  vec_t vecs[11];
  int   hi[32];
  int   n;
  int   el_hold;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.trace_done = 1'b0; bus.total_screens = 5'd5;

    // Normal flow with total=5: {start, total, cycles, screen, change, eog, again, elapsed}
    vecs[0]  = '{1'b1, 5'd5, 1,  1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 5'd5, 3,  1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 5'd5, 1,  2, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 5'd5, 1,  2, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 5'd5, 23, 3, 1'b1, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, 5'd5, 12, 4, 1'b1, 1'b0, 1'b0, 5};
    vecs[6]  = '{1'b0, 5'd5, 24, 5, 1'b1, 1'b1, 1'b0, 8};
    vecs[7]  = '{1'b0, 5'd5, 7,  5, 1'b0, 1'b1, 1'b0, 8};
    vecs[8]  = '{1'b0, 5'd5, 1,  1, 1'b1, 1'b0, 1'b1, 0};
    vecs[9]  = '{1'b0, 5'd5, 1,  1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 5'd5, 4,  2, 1'b1, 1'b0, 1'b0, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.start = vecs[i].start;
      bus.total_screens = vecs[i].tot;
      repeat (vecs[i].cycles) cycle("vec");
      expect_val($sformatf("vec%0d_screen", i), int'(bus.curr_screen), vecs[i].scr);
      expect_val($sformatf("vec%0d_change", i), int'(bus.screen_change), int'(vecs[i].chg));
      expect_val($sformatf("vec%0d_eog", i), int'(bus.end_of_game), int'(vecs[i].eog));
      expect_val($sformatf("vec%0d_again", i), int'(bus.play_again), int'(vecs[i].pa));
      expect_val($sformatf("vec%0d_elapsed", i), int'(bus.elapsed_sec), vecs[i].el);
    end

    // Snitch window: 8 cycles on screen 2, never on screens 1 and 3.
    do_reset();
    begin_game(5'd5);
    for (int i = 0; i < 32; i++) hi[i] = 0;
    n = 0;
    while (bus.curr_screen != 5'd5 && n < 200) begin
      cycle("snitch");
      if (bus.snitch_powerup) hi[bus.curr_screen]++;
      n++;
    end
    expect_val("snitch_bound", int'(n < 200), 1);
    expect_val("snitch_scr2", hi[2], 8);
    expect_val("snitch_scr1", hi[1], 0);
    expect_val("snitch_scr3", hi[3], 0);
    expect_val("snitch_scr5", hi[5], 0);

    // Early trace completion, then trace_done ignored on a message screen.
    do_reset();
    begin_game(5'd5);
    repeat (4) cycle("early");
    expect_val("early_on2", int'(bus.curr_screen), 2);
    repeat (4) cycle("early");
    bus.trace_done = 1'b1;
    cycle("early");
    expect_val("early_to3", int'(bus.curr_screen), 3);
    expect_val("early_chg", int'(bus.screen_change), 1);
    repeat (11) cycle("msg_ignore");
    expect_val("msg_hold3", int'(bus.curr_screen), 3);
    bus.trace_done = 1'b0;
    cycle("msg_end");
    expect_val("msg_to4", int'(bus.curr_screen), 4);

    // Pause mid screen 2 inside the snitch window.
    do_reset();
    begin_game(5'd5);
    repeat (14) cycle("pre_pause");
    expect_val("pause_snitch_before", int'(bus.snitch_powerup), 1);
    el_hold = int'(bus.elapsed_sec);
    bus.pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle("pause");
      expect_val("pause_screen", int'(bus.curr_screen), 2);
      expect_val("pause_elapsed", int'(bus.elapsed_sec), el_hold);
      expect_val("pause_snitch", int'(bus.snitch_powerup), 0);
    end
    bus.pause = 1'b0;
    n = 0;
    while (bus.curr_screen == 5'd2 && n < 100) begin
      cycle("post_pause");
      n++;
    end
    expect_val("pause_remaining", n, 14);

    // total_screens=1 clamps to 2.
    do_reset();
    begin_game(5'd1);
    repeat (4) cycle("clamp");
    expect_val("clamp_screen", int'(bus.curr_screen), 2);
    expect_val("clamp_eog", int'(bus.end_of_game), 1);
    repeat (7) cycle("clamp");
    expect_val("clamp_no_again", int'(bus.play_again), 0);
    cycle("clamp");
    expect_val("clamp_again", int'(bus.play_again), 1);
    expect_val("clamp_screen1", int'(bus.curr_screen), 1);

    // Reset while in SCORE.
    do_reset();
    begin_game(5'd2);
    repeat (7) cycle("score_rst");
    expect_val("score_rst_eog_before", int'(bus.end_of_game), 1);
    resetn = 1'b0;
    cycle("score_rst");
    expect_val("score_rst_screen", int'(bus.curr_screen), 1);
    expect_val("score_rst_eog", int'(bus.end_of_game), 0);
    expect_val("score_rst_again", int'(bus.play_again), 0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle("idle_hold");
      expect_val("idle_no_again", int'(bus.play_again), 0);
    end

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      resetn            = ($urandom_range(0, 599) != 0);
      bus.start         = ($urandom_range(0, 3) == 0);
      bus.pause         = ($urandom_range(0, 5) == 0);
      bus.trace_done    = ($urandom_range(0, 7) == 0);
      bus.total_screens = 5'($urandom_range(0, 9));
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Game-flow controller that sequences the display screens: title, then alternating trace screens (even numbers) and message screens (odd numbers), then the score board, then automatic replay.
- Owns the per-screen timing, the snitch power-up window, pause, early trace completion and the end-of-game/play-again handshake.
- Drives curr_screen to the VGA/screen mux and score logic.
- Replaces free-running cycle comparisons with a parameterized tick prescaler, so durations are exact and simulation can be shortened.

Parameters:
- TICK_CYCLES, 12_500_000, clock cycles per tick (0.25 s at 50 MHz)
- TICKS_PER_SEC, 4, ticks per elapsed second
- TITLE_TICKS, 1, title screen duration in ticks
- TRACE_TICKS, 80, trace (even) screen duration in ticks
- MSG_TICKS, 20, message (odd) screen duration in ticks
- SCORE_TICKS, 16, score board hold before replay, in ticks
- SNITCH_ON, 32, first trace tick (inclusive) of the snitch window
- SNITCH_OFF, 60, last trace tick (exclusive) of the snitch window

Ports:
- clock  in  1  system clock
- resetn  in  1  reset; **synchronous and active-low**, asserted by driving low
- start  in  1  level; leaves IDLE when high
- pause  in  1  level; freezes all timing while high
- trace_done  in  1  player finished the current trace; honoured only in TRACE
- total_screens  in  5  number of the final (score board) screen
- curr_screen  out  5  current screen number, 1..total
- screen_change  out  1  1-cycle pulse in the cycle curr_screen takes a new value
- elapsed_sec  out  16  seconds of play since the last start or replay; saturates at 0xFFFF
- snitch_powerup  out  1  high during the snitch window of a trace screen
- end_of_game  out  1  high throughout SCORE
- play_again  out  1  1-cycle pulse when replay begins

Behaviour:
- Reset values (resetn low at a clock edge): state IDLE, curr_screen 1, prescaler 0, tick count 0, elapsed_sec 0, all 1-bit outputs 0, total register 2.
  - Reset mid-operation overrides everything in that cycle.
- Tick prescaler:
  - Counts 0..TICK_CYCLES-1; tick pulses on the wrap cycle.
  - Held (not cleared) while pause=1 or in IDLE.
  - Cleared on every screen change, so each screen gets exactly N*TICK_CYCLES cycles.
- Tick count (8 bits): increments on tick, clears on screen change. A screen ends on the cycle where tick=1 and tick count = LIMIT-1.
- IDLE:
  - curr_screen=1; wait for start=1.
  - On start, latch total_screens, clamped to a minimum of 2, then go to TITLE. Clear elapsed_sec.
  - start is ignored in every other state.
- TITLE (screen 1): after TITLE_TICKS, curr_screen<=2.
- Next-screen rule (TITLE, TRACE, MESSAGE):
  - Next = curr_screen+1.
  - If next == total, go to SCORE.
  - Otherwise go to TRACE if next is even, MESSAGE if next is odd.
- TRACE (even screens):
  - Ends after TRACE_TICKS, or on the cycle after trace_done=1, whichever is first.
  - snitch_powerup = 1 while SNITCH_ON <= tick count < SNITCH_OFF and pause=0 (registered).
- MESSAGE (odd, >1): ends after MSG_TICKS; trace_done is ignored.
- SCORE:
  - curr_screen=total; end_of_game=1.
  - After SCORE_TICKS, go to RESTART.
- RESTART (single cycle):
  - play_again pulses 1; curr_screen<=1; screen_change=1; elapsed_sec<=0.
  - Next state is TITLE (automatic replay).
  - total_screens is re-latched.
- elapsed_sec:
  - A sub-counter of ticks mod TICKS_PER_SEC runs in TITLE/TRACE/MESSAGE only.
  - It is not cleared on screen change.
  - elapsed_sec increments on each wrap of the sub-counter.
- Pause:
  - No state change, tick or elapsed count while high; pause has priority over trace_done and over an expiring tick.
  - trace_done seen during pause is dropped, not queued.
- total_screens changes outside IDLE/RESTART have no effect.
- Screen arithmetic is 5-bit; since total ≤ 31, curr_screen never wraps.

Decomposition:
- Package screen_pkg:
  - State enum (IDLE, TITLE, TRACE, MESSAGE, SCORE, RESTART).
  - Screen width (5).
  - Tick count width (8).
- Sub-module tick_gen:
  - Prescaler with enable and synchronous clear.
  - Outputs the 1-cycle tick.
- The FSM, counters and outputs live in screen_sequencer.

Test Plan:
Bench parameters: TICK_CYCLES=4, TICKS_PER_SEC=2, TITLE=1, TRACE=6, MSG=3, SCORE=2, SNITCH 2..4, total_screens=5.
- Normal flow: reset, then start=1.
  - Required sequence: curr_screen 1→2 (4 cycles), →3 (24), →4 (12), →5 (24) with end_of_game=1.
  - Then 8 cycles later play_again pulses 1 cycle and curr_screen=1.
  - screen_change pulses once per step.
- Snitch window: on screen 2, snitch_powerup is high for exactly ticks 2–3 (8 cycles) and low otherwise; it never asserts on screens 1, 3 or 5.
- Early trace: trace_done=1 at tick 1 of screen 2 → curr_screen=3 on the next cycle. trace_done on screen 3 → no effect.
- Pause: pause=1 for 50 cycles mid screen 2 → curr_screen, elapsed_sec and the prescaler are frozen, and snitch_powerup is 0; on release, the remaining duration is unchanged.
- Boundaries:
  - total_screens=1 at start → clamped to 2: screen 1 then SCORE on screen 2.
  - resetn=0 during SCORE → next cycle IDLE, curr_screen=1, end_of_game=0, no play_again pulse.
- elapsed_sec: after the full normal flow up to screen 5, elapsed_sec=8 (16 ticks / 2); it stays frozen during SCORE and is cleared at play_again.
